// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard of EX/MEM/WB destinations,
// load-use / RAW stall detection, branch flushes, operand-forward selects and event counters.
module hazard_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_wR,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] wr;
    logic       we;
    logic       ld;
  } sb_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  sb_t  s_ex, s_mem, s_wb;
  logic hz_ex, hz_mem, hz_wb;
  logic hazard;
  logic stall;

  // x0 is hard-wired to zero, so it can never carry a dependency.
  function automatic logic match(input logic [4:0] rs, input logic used,
                                 input logic valid, input sb_t s);
    return used & valid & (rs != 5'd0) & s.v & s.we & (s.wr == rs);
  endfunction

  function automatic logic [1:0] fwd_src(input logic [4:0] rs, input logic used,
                                         input logic valid, input sb_t ex,
                                         input sb_t mem, input sb_t wb);
    if (!FWD_EN)                      return SEL_RF;
    if (match(rs, used, valid, ex))   return SEL_EX;
    if (match(rs, used, valid, mem))  return SEL_MEM;
    if (match(rs, used, valid, wb))   return SEL_WB;
    return SEL_RF;
  endfunction

  assign hz_ex  = match(id_rs1, id_rs1_used, id_valid, s_ex)
                | match(id_rs2, id_rs2_used, id_valid, s_ex);
  assign hz_mem = match(id_rs1, id_rs1_used, id_valid, s_mem)
                | match(id_rs2, id_rs2_used, id_valid, s_mem);
  assign hz_wb  = match(id_rs1, id_rs1_used, id_valid, s_wb)
                | match(id_rs2, id_rs2_used, id_valid, s_wb);

  // With forwarding only a load in EX is too late to forward; otherwise wait for WB to retire.
  assign hazard = FWD_EN ? (hz_ex & s_ex.ld) : (hz_ex | hz_mem | hz_wb);

  // A taken branch kills the ID instruction anyway, so it wins over any hazard.
  assign stall      = hazard & ~ex_branch_taken;
  assign stall_pc   = stall;
  assign stall_ifid = stall;
  assign flush_ifid = ex_branch_taken;
  assign flush_idex = stall | ex_branch_taken;

  assign fwd_a_sel = fwd_src(id_rs1, id_rs1_used, id_valid, s_ex, s_mem, s_wb);
  assign fwd_b_sel = fwd_src(id_rs2, id_rs2_used, id_valid, s_ex, s_mem, s_wb);

  // Load flags of MEM/WB (and of EX without forwarding) are kept only to mirror the pipeline.
  logic unused_ld;
  assign unused_ld = s_mem.ld ^ s_wb.ld ^ (s_ex.ld & ~FWD_EN);

  // NOTE: all state uses non-blocking assignments so the EX->MEM->WB shift reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ex      <= '0;
      s_mem     <= '0;
      s_wb      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      s_wb  <= s_mem;
      s_mem <= s_ex;
      if (flush_idex) s_ex <= '0;
      else            s_ex <= '{v: id_valid, wr: id_wR, we: id_rf_we, ld: id_is_load};
      if (stall && (stall_cnt != '1))           stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_branch_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: one forwarding instance, one stall-only instance
// with 3-bit counters; per-cycle expected outputs go through a scoreboard queue.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rf_we, id_is_load, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_wR;

  logic        sp_f, si_f, fi_f, fx_f;
  logic [1:0]  fa_f, fb_f;
  logic [31:0] scnt_f, fcnt_f;
  logic        sp_n, si_n, fi_n, fx_n;
  logic [1:0]  fa_n, fb_n;
  logic [2:0]  scnt_n, fcnt_n;

  logic [7:0] obs_f, obs_n;
  assign obs_f = {sp_f, si_f, fi_f, fx_f, fa_f, fb_f};
  assign obs_n = {sp_n, si_n, fi_n, fx_n, fa_n, fb_n};

  hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wR(id_wR),
    .id_rf_we(id_rf_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .stall_pc(sp_f), .stall_ifid(si_f), .flush_ifid(fi_f), .flush_idex(fx_f),
    .fwd_a_sel(fa_f), .fwd_b_sel(fb_f), .stall_cnt(scnt_f), .flush_cnt(fcnt_f));

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(3)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wR(id_wR),
    .id_rf_we(id_rf_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .stall_pc(sp_n), .stall_ifid(si_n), .flush_ifid(fi_n), .flush_idex(fx_n),
    .fwd_a_sel(fa_n), .fwd_b_sel(fb_n), .stall_cnt(scnt_n), .flush_cnt(fcnt_n));

  always #5 clk = ~clk;

  // Expected word: {stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel}
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] wr;
    logic       we;
    logic       ld;
    logic       br;
    logic [7:0] exp;
  } row_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  function automatic row_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] wr,
                              input logic we, input logic ld, input logic br,
                              input logic [7:0] exp);
    return '{v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, wr: wr, we: we, ld: ld, br: br, exp: exp};
  endfunction

  task automatic drive(input row_t r);
    id_valid = r.v; id_rs1 = r.rs1; id_rs1_used = r.u1; id_rs2 = r.rs2; id_rs2_used = r.u2;
    id_wR = r.wr; id_rf_we = r.we; id_is_load = r.ld; ex_branch_taken = r.br;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    drive(mk(1, 5, 1, 6, 1, 7, 1, 1, 0, 8'h00));
    exp_q.push_back(8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (obs_f !== e || obs_n !== e || scnt_f !== 32'd0 || fcnt_f !== 32'd0 ||
        scnt_n !== 3'd0 || fcnt_n !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_hold: f=%h n=%h cnt=%0d/%0d/%0d/%0d want %h and zero counters",
               obs_f, obs_n, scnt_f, fcnt_f, scnt_n, fcnt_n, e);
    end
    rst = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (obs_f !== e || obs_n !== e) begin
      miscompares++;
      $display("FAIL reset_first_cycle: f=%h n=%h want %h", obs_f, obs_n, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    row_t rows[7];
    logic [7:0] e;
    do_reset();
    rows[0] = mk(1, 0, 1, 0, 0, 5, 1, 0, 0, 8'h00);   // addi x5,x0
    rows[1] = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 8'h04);   // add x6,x5,x1  : x5 in EX
    rows[2] = mk(1, 1, 1, 5, 1, 7, 1, 0, 0, 8'h02);   // sub x7,x1,x5  : x5 in MEM
    rows[3] = mk(1, 5, 1, 6, 1, 8, 1, 0, 0, 8'h0E);   // and x8,x5,x6  : WB / MEM
    rows[4] = mk(1, 0, 1, 0, 0, 9, 1, 0, 0, 8'h00);   // addi x9,x0
    rows[5] = mk(1, 0, 1, 0, 0, 9, 1, 0, 0, 8'h00);   // addi x9,x0
    rows[6] = mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 8'h05);  // add x10,x9,x9 : EX beats MEM
    for (int i = 0; i < 7; i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs_f !== e) begin
        miscompares++;
        $display("FAIL forward[%0d]: got %b want %b", i, obs_f, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (scnt_f !== 32'd0) begin
      miscompares++;
      $display("FAIL forward_stall_cnt: got %0d want 0", scnt_f);
    end
  endtask

  task automatic test_load_use();
    row_t rows[3];
    logic [7:0] e;
    do_reset();
    rows[0] = mk(1, 2, 1, 0, 0, 7, 1, 1, 0, 8'h00);   // lw x7,0(x2)
    rows[1] = mk(1, 7, 1, 2, 1, 8, 1, 0, 0, 8'hD4);   // sub x8,x7,x2 : stall
    rows[2] = mk(1, 7, 1, 2, 1, 8, 1, 0, 0, 8'h08);   // re-evaluated : x7 from MEM
    for (int i = 0; i < 3; i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs_f !== e) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs_f, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (scnt_f !== 32'd1 || fcnt_f !== 32'd0) begin
      miscompares++;
      $display("FAIL load_use_cnt: stall=%0d flush=%0d want 1/0", scnt_f, fcnt_f);
    end
  endtask

  task automatic test_branch_override();
    row_t rows[3];
    logic [7:0] e;
    do_reset();
    rows[0] = mk(1, 2, 1, 0, 0, 7, 1, 1, 0, 8'h00);   // lw x7
    rows[1] = mk(1, 7, 1, 2, 1, 8, 1, 0, 1, 8'h34);   // load-use + taken branch
    rows[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs_f !== e) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %b want %b", i, obs_f, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (fcnt_f !== 32'd1 || scnt_f !== 32'd0) begin
      miscompares++;
      $display("FAIL branch_cnt: flush=%0d stall=%0d want 1/0", fcnt_f, scnt_f);
    end
  endtask

  task automatic test_x0_unused();
    row_t rows[7];
    logic [7:0] e;
    do_reset();
    rows[0] = mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 8'h00);   // addi x0,x1
    rows[1] = mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 8'h00);   // add x1,x0,x0
    rows[2] = mk(1, 0, 1, 0, 0, 11, 1, 1, 0, 8'h00);  // lw x11,0(x0)
    rows[3] = mk(1, 0, 1, 11, 0, 12, 1, 0, 0, 8'h00); // rs2=x11 but not read
    rows[4] = mk(0, 12, 1, 11, 1, 0, 0, 0, 0, 8'h00); // id_valid=0
    rows[5] = mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 8'h00);   // lw x0
    rows[6] = mk(1, 0, 1, 0, 1, 13, 1, 0, 0, 8'h00);  // reads x0 after lw x0
    for (int i = 0; i < 7; i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs_f !== e || obs_n !== e) begin
        miscompares++;
        $display("FAIL x0_unused[%0d]: f=%b n=%b want %b", i, obs_f, obs_n, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (scnt_f !== 32'd0 || scnt_n !== 3'd0) begin
      miscompares++;
      $display("FAIL x0_unused_cnt: f=%0d n=%0d want 0", scnt_f, scnt_n);
    end
  endtask

  task automatic test_no_fwd();
    row_t rows[5];
    logic [7:0] e;
    do_reset();
    rows[0] = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 8'h00);   // add x3,x1,x2
    rows[1] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);   // or x4,x3,x3 : x3 in EX
    rows[2] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);   // x3 in MEM
    rows[3] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);   // x3 in WB
    rows[4] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'h00);   // retired, regfile read
    for (int i = 0; i < 5; i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs_n !== e) begin
        miscompares++;
        $display("FAIL no_fwd[%0d]: got %b want %b", i, obs_n, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (scnt_n !== 3'd3) begin
      miscompares++;
      $display("FAIL no_fwd_stall_cnt: got %0d want 3", scnt_n);
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t add_r, or_r;
    logic [7:0] e;
    do_reset();
    add_r = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 8'h00);
    or_r  = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);
    drive(add_r);
    @(posedge clk); #1;
    drive(or_r);
    @(posedge clk); #1;
    exp_q.push_back(8'hD0);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (obs_n !== e || scnt_n !== 3'd1) begin
      miscompares++;
      $display("FAIL mid_stall_pre: got %b cnt=%0d want %b cnt=1", obs_n, scnt_n, e);
    end
    rst = 1'b1;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (obs_n !== e || scnt_n !== 3'd0 || fcnt_n !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_stall_rst: got %b cnt=%0d/%0d want %b and 0/0", obs_n, scnt_n, fcnt_n, e);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      if (i == 1) @(negedge clk);
      else #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs_n !== e || scnt_n !== 3'd0) begin
        miscompares++;
        $display("FAIL mid_stall_after[%0d]: got %b cnt=%0d want %b cnt=0", i, obs_n, scnt_n, e);
      end
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    row_t grp[5];
    logic [7:0] e;
    do_reset();
    grp[0] = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 8'h00);
    grp[1] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);
    grp[2] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);
    grp[3] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'hD0);
    grp[4] = mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 8'h00);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 5; i++) begin
        drive(grp[i]);
        exp_q.push_back(grp[i].exp);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (obs_n !== e) begin
          miscompares++;
          $display("FAIL sat_stall[%0d][%0d]: got %b want %b", g, i, obs_n, e);
        end
        @(posedge clk); #1;
      end
      vectors++;
      if (scnt_n !== ((g == 2) ? 3'd7 : 3'((g + 1) * 3))) begin
        miscompares++;
        $display("FAIL sat_stall_cnt[%0d]: got %0d", g, scnt_n);
      end
    end
    for (int i = 0; i < 9; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h30));
      exp_q.push_back(8'h30);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs_n !== e) begin
        miscompares++;
        $display("FAIL sat_flush[%0d]: got %b want %b", i, obs_n, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (fcnt_n !== 3'd7 || scnt_n !== 3'd7) begin
      miscompares++;
      $display("FAIL sat_final: flush=%0d stall=%0d want 7/7", fcnt_n, scnt_n);
    end
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    test_reset();
    test_forward();
    test_load_use();
    test_branch_override();
    test_x0_unused();
    test_no_fwd();
    test_reset_mid_stall();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
